// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc: round-robin multi-channel HC-SR04 ranging engine.
// Fires one sensor at a time, measures its echo width in clock cycles, reports
// each result on a one-cycle strobe and keeps per-channel near flags with hysteresis.
module ultrasonic_ranger_mc #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned W           = 26,
    parameter int unsigned GAP_CYC     = 7500000,
    parameter int unsigned TRIG_CYC    = 500,
    parameter int unsigned TIMEOUT_CYC = 1500000,
    parameter int unsigned THRESH      = 20000,
    parameter int unsigned HYST        = 2000,
    parameter int unsigned CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_50M,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [N_CH-1:0] echo,
    output logic [N_CH-1:0] trigger,
    output logic            width_valid,
    output logic [CW-1:0]   width_ch,
    output logic [W-1:0]    width_data,
    output logic            timeout,
    output logic [N_CH-1:0] near
);

    localparam logic [W-1:0]  GAP_LAST  = W'(GAP_CYC - 1);
    localparam logic [W-1:0]  TRIG_LAST = W'(TRIG_CYC - 1);
    localparam logic [W-1:0]  TO_LAST   = W'(TIMEOUT_CYC - 1);
    localparam logic [W-1:0]  TO_VAL    = W'(TIMEOUT_CYC);
    localparam logic [W-1:0]  NEAR_SET  = W'(THRESH);
    localparam logic [W-1:0]  NEAR_REL  = W'(THRESH + HYST);
    localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        COUNT,
        REPORT
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    cnt, cnt_n;
    logic [CW-1:0]   ch, ch_n;
    logic [N_CH-1:0] echo_m, e_s, e_d;
    logic [N_CH-1:0] ch_sel;
    logic [N_CH-1:0] trigger_n;
    logic            valid_n;
    logic [CW-1:0]   width_ch_n;
    logic [W-1:0]    width_data_n;
    logic            timeout_n;
    logic [N_CH-1:0] near_n;

    // Two-flop synchroniser per echo line plus one delayed copy for edge detection.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            echo_m <= '0;
            e_s    <= '0;
            e_d    <= '0;
        end else begin
            echo_m <= echo;
            e_s    <= echo_m;
            e_d    <= e_s;
        end
    end

    // Next-state, counter and registered-output decode; only channel ch is ever looked at.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ch_n         = ch;
        ch_sel       = N_CH'(1) << ch;
        trigger_n    = '0;
        valid_n      = 1'b0;
        width_ch_n   = width_ch;
        width_data_n = width_data;
        timeout_n    = timeout;
        near_n       = near;
        case (state)
            IDLE: begin
                if (!enable) begin
                    cnt_n = '0;
                end else if (cnt == GAP_LAST) begin
                    cnt_n     = '0;
                    state_n   = TRIG;
                    trigger_n = ch_sel;
                end else begin
                    cnt_n = cnt + W'(1);
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT_RISE;
                end else begin
                    cnt_n     = cnt + W'(1);
                    trigger_n = ch_sel;
                end
            end
            WAIT_RISE: begin
                if (e_s[ch] && !e_d[ch]) begin
                    cnt_n   = W'(1);
                    state_n = COUNT;
                end else if (cnt >= TO_LAST) begin
                    state_n      = REPORT;
                    valid_n      = 1'b1;
                    width_ch_n   = ch;
                    width_data_n = TO_VAL;
                    timeout_n    = 1'b1;
                    near_n[ch]   = 1'b0;
                end else begin
                    cnt_n = cnt + W'(1);
                end
            end
            COUNT: begin
                if (!e_s[ch]) begin
                    state_n      = REPORT;
                    valid_n      = 1'b1;
                    width_ch_n   = ch;
                    width_data_n = cnt;
                    timeout_n    = 1'b0;
                    if (cnt <= NEAR_SET) begin
                        near_n[ch] = 1'b1;
                    end else if (cnt > NEAR_REL) begin
                        near_n[ch] = 1'b0;
                    end
                end else if (cnt >= TO_LAST) begin
                    state_n      = REPORT;
                    valid_n      = 1'b1;
                    width_ch_n   = ch;
                    width_data_n = TO_VAL;
                    timeout_n    = 1'b1;
                    near_n[ch]   = 1'b0;
                end else begin
                    cnt_n = cnt + W'(1);
                end
            end
            REPORT: begin
                cnt_n   = '0;
                state_n = IDLE;
                ch_n    = (ch == CH_LAST) ? '0 : ch + CW'(1);
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset drops trigger asynchronously.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ch          <= '0;
            trigger     <= '0;
            width_valid <= 1'b0;
            width_ch    <= '0;
            width_data  <= '0;
            timeout     <= 1'b0;
            near        <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ch          <= ch_n;
            trigger     <= trigger_n;
            width_valid <= valid_n;
            width_ch    <= width_ch_n;
            width_data  <= width_data_n;
            timeout     <= timeout_n;
            near        <= near_n;
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Bench for ultrasonic_ranger_mc: a negedge monitor records trigger pulses and
// strobes and plays scheduled echo pulses; scenario tasks compare against a
// channel-level model (round-robin pointer, near flags, expected width).
`timescale 1ns/1ps
module tb_ultrasonic_ranger_mc;

    localparam int N_CH  = 3;
    localparam int W     = 26;
    localparam int CW    = 2;
    localparam int GAP   = 100;
    localparam int TRIGC = 10;
    localparam int TO    = 1000;
    localparam int TH    = 200;
    localparam int HY    = 20;
    localparam int BOUND = 5000;

    logic            clk_50M = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [N_CH-1:0] echo;
    logic [N_CH-1:0] trigger;
    logic            width_valid;
    logic [CW-1:0]   width_ch;
    logic [W-1:0]    width_data;
    logic            timeout;
    logic [N_CH-1:0] near;

    ultrasonic_ranger_mc #(
        .N_CH(N_CH), .W(W), .GAP_CYC(GAP), .TRIG_CYC(TRIGC),
        .TIMEOUT_CYC(TO), .THRESH(TH), .HYST(HY), .CW(CW)
    ) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .enable(enable), .echo(echo),
        .trigger(trigger), .width_valid(width_valid), .width_ch(width_ch),
        .width_data(width_data), .timeout(timeout), .near(near)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        int              ch;
        logic [N_CH-1:0] val;
        int              start;
        int              len;
    } trig_t;

    typedef struct {
        int              ch;
        int              data;
        logic            to;
        logic [N_CH-1:0] nr;
        int              at;
    } strobe_t;

    trig_t     trig_q[$];
    strobe_t   strb_q[$];
    int        cyc;
    int        sched_start[N_CH];
    int        sched_end[N_CH];
    bit        dbl_valid;
    int        n_vec, n_fail;
    int        model_ch;
    bit [N_CH-1:0] model_near;

    // Monitor and echo player, all on the falling edge.
    initial begin : monitor
        logic [N_CH-1:0] prev_t;
        logic            prev_v;
        trig_t           cur;
        strobe_t         sb;
        cyc = 0; echo = '0; dbl_valid = 1'b0; prev_t = '0; prev_v = 1'b0;
        cur.ch = -1; cur.val = '0; cur.start = 0; cur.len = 0;
        for (int i = 0; i < N_CH; i++) begin sched_start[i] = 0; sched_end[i] = 0; end
        forever begin
            @(negedge clk_50M);
            cyc++;
            if (trigger != '0 && prev_t == '0) begin
                cur.val = trigger; cur.start = cyc; cur.len = 0; cur.ch = -1;
                for (int i = 0; i < N_CH; i++) if (trigger[i]) cur.ch = i;
            end
            if (trigger != '0) cur.len++;
            if (trigger == '0 && prev_t != '0) trig_q.push_back(cur);
            prev_t = trigger;
            if (width_valid === 1'b1) begin
                sb.ch = int'(width_ch); sb.data = int'(width_data); sb.to = timeout;
                sb.nr = near; sb.at = cyc;
                strb_q.push_back(sb);
                if (prev_v) dbl_valid = 1'b1;
            end
            prev_v = width_valid;
            for (int i = 0; i < N_CH; i++) echo[i] = (cyc >= sched_start[i]) && (cyc < sched_end[i]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #2;
    endtask

    task automatic wait_trig(output trig_t t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND && !ok; i++) begin
            if (trig_q.size() != 0) begin t = trig_q.pop_front(); ok = 1'b1; end
            else tick(1);
        end
    endtask

    task automatic wait_strobe(output strobe_t s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND && !ok; i++) begin
            if (strb_q.size() != 0) begin s = strb_q.pop_front(); ok = 1'b1; end
            else tick(1);
        end
    endtask

    // One measurement: wait for the trigger, play a p-cycle echo dly cycles later (p=0: none).
    task automatic run_channel(input int p, input int dly, output trig_t t, output strobe_t s, output bit ok);
        bit ok1, ok2;
        wait_trig(t, ok1);
        if (ok1 && p > 0 && t.ch >= 0 && t.ch < N_CH) begin
            sched_start[t.ch] = cyc + dly;
            sched_end[t.ch]   = cyc + dly + p;
        end
        wait_strobe(s, ok2);
        ok = ok1 && ok2;
    endtask

    // Reference model: a pulse of p cycles reads back as p unless it reaches the timeout.
    function automatic void model_expect(input int p, output bit eto, output int ew);
        if (p <= 0 || p >= TO) begin eto = 1'b1; ew = TO; end
        else begin eto = 1'b0; ew = p; end
    endfunction

    function automatic void model_commit(input bit eto, input int ew);
        if (eto) model_near[model_ch] = 1'b0;
        else if (ew <= TH) model_near[model_ch] = 1'b1;
        else if (ew > TH + HY) model_near[model_ch] = 1'b0;
        model_ch = (model_ch + 1) % N_CH;
    endfunction

    task automatic advance_to(input int target, input int p, output bit ok);
        trig_t t; strobe_t s; bit k_ok, eto; int ew;
        ok = 1'b1;
        while (model_ch != target && ok) begin
            run_channel(p, 5, t, s, k_ok);
            ok = k_ok;
            model_expect(p, eto, ew);
            model_commit(eto, ew);
        end
    endtask

    task automatic test_reset();
        trig_t t; strobe_t s; bit ok; int rel;
        rst_n = 1'b0; enable = 1'b1;
        tick(5);
        n_vec++; if (trigger !== '0) begin n_fail++; $display("FAIL rst_trigger: got %b want 000", trigger); end
        n_vec++; if (width_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", width_valid); end
        n_vec++; if (width_ch !== '0) begin n_fail++; $display("FAIL rst_ch: got %0d want 0", width_ch); end
        n_vec++; if (width_data !== '0) begin n_fail++; $display("FAIL rst_data: got %0d want 0", width_data); end
        n_vec++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        n_vec++; if (near !== '0) begin n_fail++; $display("FAIL rst_near: got %b want 000", near); end
        trig_q.delete(); strb_q.delete();
        rst_n = 1'b1; rel = cyc;
        model_ch = 0; model_near = '0;
        run_channel(0, 0, t, s, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL first_meas: no trigger/strobe within %0d cycles", BOUND); end
        else begin
            // first high sample is the negedge after the GAP-th posedge following release
            if (t.start - rel !== GAP + 1) begin n_fail++; $display("FAIL first_trig_delay: got %0d want %0d", t.start - rel, GAP + 1); end
            n_vec++; if (t.len !== TRIGC) begin n_fail++; $display("FAIL first_trig_len: got %0d want %0d", t.len, TRIGC); end
            n_vec++; if (t.val !== 3'b001) begin n_fail++; $display("FAIL first_trig_ch: got %b want 001", t.val); end
            n_vec++; if (s.ch !== 0) begin n_fail++; $display("FAIL first_ch: got %0d want 0", s.ch); end
            n_vec++; if (s.data !== TO) begin n_fail++; $display("FAIL first_data: got %0d want %0d", s.data, TO); end
            n_vec++; if (s.to !== 1'b1) begin n_fail++; $display("FAIL first_to: got %b want 1", s.to); end
            n_vec++; if (s.nr !== 3'b000) begin n_fail++; $display("FAIL first_near: got %b want 000", s.nr); end
        end
        model_commit(1'b1, TO);
    endtask

    task automatic test_round_robin();
        trig_t t; strobe_t s; bit ok, eto; int p, sel, ew;
        logic [N_CH-1:0] ev;
        for (int k = 0; k < 8; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) p = 0;
            else if (sel == 1) p = int'($urandom_range(1050, 1200));
            else begin
                p = int'($urandom_range(20, 960));
                if (p >= 195 && p <= 225) p = p + 40;
            end
            model_expect(p, eto, ew);
            run_channel(p, int'($urandom_range(3, 60)), t, s, ok);
            ev = '0; ev[model_ch] = 1'b1;
            n_vec++;
            if (!ok) begin n_fail++; $display("FAIL rr_bound: step %0d no strobe", k); end
            else begin
                if (t.val !== ev) begin n_fail++; $display("FAIL rr_trig: step %0d got %b want %b", k, t.val, ev); end
                n_vec++; if (t.len !== TRIGC) begin n_fail++; $display("FAIL rr_trig_len: got %0d want %0d", t.len, TRIGC); end
                n_vec++; if (s.ch !== model_ch) begin n_fail++; $display("FAIL rr_ch: got %0d want %0d", s.ch, model_ch); end
                n_vec++; if (eto ? (s.data !== ew) : (s.data < ew - 1 || s.data > ew + 1)) begin
                    n_fail++; $display("FAIL rr_data: p=%0d got %0d want %0d", p, s.data, ew); end
                n_vec++; if (s.to !== eto) begin n_fail++; $display("FAIL rr_to: p=%0d got %b want %b", p, s.to, eto); end
                model_commit(eto, ew);
                n_vec++; if (s.nr !== model_near) begin n_fail++; $display("FAIL rr_near: p=%0d got %b want %b", p, s.nr, model_near); end
            end
        end
    endtask

    task automatic test_hysteresis();
        trig_t t; strobe_t s; bit ok, eto; int ew;
        int hw[4]; bit hn[4];
        hw = '{150, 210, 221, 210};
        hn = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            advance_to(0, int'($urandom_range(30, 180)), ok);
            n_vec++; if (!ok) begin n_fail++; $display("FAIL hyst_adv: step %0d no strobe", k); end
            model_expect(hw[k], eto, ew);
            run_channel(hw[k], int'($urandom_range(3, 30)), t, s, ok);
            n_vec++;
            if (!ok) begin n_fail++; $display("FAIL hyst_bound: step %0d no strobe", k); end
            else begin
                if (s.ch !== 0) begin n_fail++; $display("FAIL hyst_ch: got %0d want 0", s.ch); end
                n_vec++; if (s.data < ew - 1 || s.data > ew + 1) begin n_fail++; $display("FAIL hyst_data: got %0d want %0d", s.data, ew); end
                n_vec++; if (s.to !== 1'b0) begin n_fail++; $display("FAIL hyst_to: got %b want 0", s.to); end
                n_vec++; if (s.nr[0] !== hn[k]) begin n_fail++; $display("FAIL hyst_near0: width %0d got %b want %b", hw[k], s.nr[0], hn[k]); end
            end
            model_commit(eto, ew);
        end
    endtask

    task automatic test_stuck_high();
        trig_t t; strobe_t s; bit ok;
        advance_to(1, 60, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL stuck_adv: no strobe"); end
        run_channel(100, 5, t, s, ok);
        model_commit(1'b0, 100);
        n_vec++; if (!ok || s.nr[1] !== 1'b1) begin n_fail++; $display("FAIL stuck_pre_near1: got %b want 1", s.nr[1]); end
        advance_to(1, 60, ok);
        sched_start[1] = cyc; sched_end[1] = cyc + 100000;
        run_channel(0, 0, t, s, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL stuck_bound: no strobe"); end
        else begin
            if (t.ch !== 1) begin n_fail++; $display("FAIL stuck_trig_ch: got %0d want 1", t.ch); end
            n_vec++; if (s.ch !== 1) begin n_fail++; $display("FAIL stuck_ch: got %0d want 1", s.ch); end
            n_vec++; if (s.to !== 1'b1) begin n_fail++; $display("FAIL stuck_to: got %b want 1", s.to); end
            n_vec++; if (s.data !== TO) begin n_fail++; $display("FAIL stuck_data: got %0d want %0d", s.data, TO); end
            n_vec++; if (s.at - (t.start + t.len) < TO - 1 || s.at - (t.start + t.len) > TO + 1) begin
                n_fail++; $display("FAIL stuck_wait: got %0d cycles want %0d", s.at - (t.start + t.len), TO); end
            n_vec++; if (s.nr[1] !== 1'b0) begin n_fail++; $display("FAIL stuck_near1: got %b want 0", s.nr[1]); end
        end
        sched_end[1] = cyc;
        model_commit(1'b1, TO);
    endtask

    task automatic test_long_noise();
        trig_t t; strobe_t s; bit ok;
        advance_to(0, 60, ok);
        sched_start[2] = cyc + 50; sched_end[2] = cyc + 400;
        run_channel(1500, 5, t, s, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL long_bound: no strobe"); end
        else begin
            if (s.to !== 1'b1) begin n_fail++; $display("FAIL long_to: got %b want 1", s.to); end
            n_vec++; if (s.data !== TO) begin n_fail++; $display("FAIL long_data: got %0d want %0d", s.data, TO); end
            n_vec++; if (s.ch !== 0) begin n_fail++; $display("FAIL long_ch: got %0d want 0", s.ch); end
        end
        model_commit(1'b1, TO);
        advance_to(0, 400, ok);
        sched_start[2] = cyc + 108; sched_end[2] = cyc + 140;
        run_channel(300, 6, t, s, ok);
        model_commit(1'b0, 300);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL noise_bound: no strobe"); end
        else begin
            if (s.ch !== 0) begin n_fail++; $display("FAIL noise_ch: got %0d want 0", s.ch); end
            n_vec++; if (s.data < 299 || s.data > 301) begin n_fail++; $display("FAIL noise_data: got %0d want 300", s.data); end
            n_vec++; if (s.to !== 1'b0) begin n_fail++; $display("FAIL noise_to: got %b want 0", s.to); end
            n_vec++; if (s.nr !== model_near) begin n_fail++; $display("FAIL noise_near: got %b want %b", s.nr, model_near); end
        end
    endtask

    task automatic test_enable_drop();
        trig_t t; strobe_t s; bit ok;
        wait_trig(t, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL en_trig: no trigger"); end
        if (ok && t.ch >= 0 && t.ch < N_CH) begin sched_start[t.ch] = cyc + 5; sched_end[t.ch] = cyc + 305; end
        tick(110);
        enable = 1'b0;
        wait_strobe(s, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL en_strobe: no strobe after enable drop"); end
        else begin
            if (s.ch !== model_ch) begin n_fail++; $display("FAIL en_ch: got %0d want %0d", s.ch, model_ch); end
            n_vec++; if (s.data < 299 || s.data > 301) begin n_fail++; $display("FAIL en_data: got %0d want 300", s.data); end
            n_vec++; if (s.to !== 1'b0) begin n_fail++; $display("FAIL en_to: got %b want 0", s.to); end
        end
        model_commit(1'b0, 300);
        tick(2000);
        n_vec++; if (trig_q.size() !== 0) begin n_fail++; $display("FAIL en_idle_trig: got %0d triggers want 0", trig_q.size()); end
        n_vec++; if (strb_q.size() !== 0) begin n_fail++; $display("FAIL en_idle_strobe: got %0d strobes want 0", strb_q.size()); end
    endtask

    task automatic test_reset_mid_trig();
        trig_t t; strobe_t s; bit ok; int rel;
        enable = 1'b1;
        for (int i = 0; i < 1000 && trigger == '0; i++) tick(1);
        n_vec++; if (trigger == '0) begin n_fail++; $display("FAIL mid_trig_start: got %b want nonzero", trigger); end
        tick(4);
        rst_n = 1'b0;
        #1;
        n_vec++; if (trigger !== '0) begin n_fail++; $display("FAIL mid_trig_drop: got %b want 000", trigger); end
        tick(3);
        n_vec++; if (strb_q.size() !== 0 || width_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_trig_strobe: got %0d strobes want 0", strb_q.size()); end
        trig_q.delete(); strb_q.delete();
        rst_n = 1'b1; rel = cyc;
        model_ch = 0; model_near = '0;
        run_channel(120, 7, t, s, ok);
        n_vec++;
        if (!ok) begin n_fail++; $display("FAIL post_rst_bound: no strobe"); end
        else begin
            if (t.start - rel !== GAP + 1) begin n_fail++; $display("FAIL post_rst_delay: got %0d want %0d", t.start - rel, GAP + 1); end
            n_vec++; if (t.ch !== 0) begin n_fail++; $display("FAIL post_rst_trig_ch: got %0d want 0", t.ch); end
            n_vec++; if (s.data < 119 || s.data > 121) begin n_fail++; $display("FAIL post_rst_data: got %0d want 120", s.data); end
            model_commit(1'b0, 120);
            n_vec++; if (s.nr !== model_near) begin n_fail++; $display("FAIL post_rst_near: got %b want %b", s.nr, model_near); end
        end
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        rst_n = 1'b0; enable = 1'b0;
        model_ch = 0; model_near = '0;
        test_reset();
        test_round_robin();
        test_hysteresis();
        test_stuck_high();
        test_long_noise();
        test_enable_drop();
        test_reset_mid_trig();
        n_vec++; if (dbl_valid) begin n_fail++; $display("FAIL back_to_back_valid: got 1 want 0"); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ultrasonic_ranger_mc.md
# ultrasonic_ranger_mc

Multi-channel, parametrised ultrasonic ranging engine for HC-SR04-class sensors on the line-following platform. It fires the sensors one at a time in round-robin order and measures each echo pulse width in clk_50M cycles. Each result is reported on a one-cycle valid strobe with its channel index. Per-channel obstacle flags with hysteresis are maintained, and a bounded timeout replaces the single-channel, unbounded echo wait of the previous generation. Results feed the motor controller's stop/avoid logic and the telemetry UART.

## Interface
- N_CH, 2: number of sensor channels (1..8).
- W, 26: width of the cycle counters and width_data.
- GAP_CYC, 7500000: idle cycles between successive triggers (150 ms at 50 MHz).
- TRIG_CYC, 500: trigger high time in cycles (10 us).
- TIMEOUT_CYC, 1500000: maximum cycles spent waiting for echo rise, and separately for echo fall (30 ms).
- THRESH, 20000: near threshold on the pulse width in cycles.
- HYST, 2000: release margin; near clears only when width > THRESH+HYST.
- CW, $clog2(N_CH) (minimum 1): width of the channel index.

- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run control, sampled only in IDLE.
- echo  in  N_CH  raw echo inputs, asynchronous to the clock.
- trigger  out  N_CH  one-hot trigger pulse, only the active channel is driven.
- width_valid  out  1  one-cycle result strobe.
- width_ch  out  CW  channel of the current result.
- width_data  out  W  measured high time in cycles, held until the next strobe.
- timeout  out  1  qualifies width_valid: the measurement timed out.
- near  out  N_CH  per-channel obstacle flag with hysteresis.

## Operation
- Each echo bit passes through a 2-FF synchroniser; all logic below uses the synchronised value e_s. The previous sample e_d is kept for edge detection.
- State IDLE: trigger=0 and cnt counts up. When cnt==GAP_CYC-1 and enable=1, cnt is cleared and the FSM goes to TRIG. While enable=0, cnt is held at 0.
- State TRIG: trigger[ch]=1 for exactly TRIG_CYC cycles. Then cnt is cleared and the FSM goes to WAIT_RISE.
- State WAIT_RISE: waits for a rising edge (e_d=0, e_s=1) on channel ch.
  - An echo already high on entry is not counted until it falls and rises again.
  - On the edge, the FSM goes to COUNT with cnt=1.
  - If cnt reaches TIMEOUT_CYC first, the FSM goes to REPORT with timeout=1.
- State COUNT: cnt increments each cycle while e_s=1.
  - On the first cycle with e_s=0, the FSM goes to REPORT with width=cnt.
  - If cnt reaches TIMEOUT_CYC, the FSM goes to REPORT with timeout=1.
- State REPORT (one cycle):
  - width_valid=1, width_ch=ch.
  - width_data=cnt on a normal result; width_data=TIMEOUT_CYC on a timeout.
  - Then ch advances (N_CH-1 wraps to 0), cnt is cleared, and the FSM returns to IDLE.
- Near update happens in REPORT for channel ch only:
  - Normal result with width<=THRESH: near[ch] is set.
  - Normal result with width>THRESH+HYST: near[ch] is cleared.
  - Normal result otherwise: near[ch] is held.
  - Timeout: near[ch] is cleared.
- All comparisons are unsigned and W-bit; cnt saturates and never wraps.
- Echo activity on inactive channels is ignored and does not disturb the active channel.

## Timing
- Reset values: trigger=0, width_valid=0, width_ch=0, width_data=0, timeout=0, near=0, state IDLE, ch=0, cnt=0, synchronisers cleared.
- Reset asserted in any state aborts immediately: trigger drops asynchronously and no strobe is issued. The first trigger after release comes GAP_CYC cycles later, on ch 0.
- Echo latency: 2 cycles from a raw edge to the registered edge decision.
- A clean raw echo pulse of P cycles reports width_data=P (±1).
- width_valid follows the synchronised echo fall by 1 cycle.
- Every outcome ends in exactly one strobe; width_valid is never high on two consecutive cycles.
- Cycle period per channel in the worst case is GAP_CYC+TRIG_CYC+2×TIMEOUT_CYC+1.
- A change of enable is seen only in IDLE; an in-flight measurement always completes.

## Test plan
Bench parameters: N_CH=3, GAP_CYC=100, TRIG_CYC=10, TIMEOUT_CYC=1000, THRESH=200, HYST=20.
- Reset release with echo=0 and enable=1 -> trigger[0] high for exactly 10 cycles starting 100 cycles after release; then a timeout strobe with width_ch=0, width_data=1000, timeout=1, near=000.
- Echo pulse of 150 cycles on ch 0 -> width_data=150±1, timeout=0, near[0]=1. The next trigger is on ch 1, then ch 2, then back to ch 0.
- Hysteresis on ch 0 with successive widths 150, 210, 221, 210 -> near[0] goes 1, 1, 0, 0.
- Echo stuck high on ch 1 from before its trigger -> no count starts; strobe with timeout=1 after 1000 cycles in WAIT_RISE; near[1]=0.
- Pulse of 1500 cycles -> timeout=1, width_data=1000. Noise pulses on ch 2 during a ch 0 measurement do not change the ch 0 result.
- enable dropped during COUNT -> the current strobe is still issued, then no further trigger. Reset asserted mid-TRIG -> trigger=0 immediately and no strobe.
